fetch_prefetch_unit: RTL and testbench

//  Parametrised instruction-fetch stage for the pipelined MIPS core. Owns the PC, issues
//  req/ack reads to instruction memory (variable latency) and buffers fetched words in a

---
 rtl/fetch_prefetch_if.sv | 23 ++
 rtl/fetch_prefetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_prefetch_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_if.sv
// Bundles the instruction-memory request channel and the IF/ID handoff of the fetch stage.
interface fetch_prefetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            if_id_valid;
  logic [31:0]     if_id_instr;
  logic [XLEN-1:0] if_id_pc_plus4;
  logic            if_id_ready;

  modport master (
    output imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc_plus4,
    input  imem_ack, imem_rdata, if_id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc_plus4,
    output imem_ack, imem_rdata, if_id_ready
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding memory reads and buffers
// fetched words in a small circular prefetch queue feeding decode.
module fetch_prefetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  fetch_prefetch_if.master         bus,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] fetch_pc, req_addr, addr_plus, redirect_aligned;
  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc4_mem   [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_after;
  logic            valid, ack, push, pop;

  assign valid            = (count != '0);
  assign ack              = bus.imem_ack && (state != IDLE);
  assign push             = (state == WAIT) && ack && !redirect;
  assign pop              = valid && bus.if_id_ready && !redirect;
  assign count_after      = count - CW'(pop) + CW'(push);
  assign addr_plus        = req_addr + XLEN'(PC_STEP);
  assign redirect_aligned = redirect_pc & ~XLEN'(3);

  // The address is held in req_addr once a request is live, so a redirect can move
  // fetch_pc without disturbing the outstanding read.
  assign bus.imem_req       = (state != IDLE);
  assign bus.imem_addr      = (state == IDLE) ? fetch_pc : req_addr;
  assign bus.if_id_valid    = valid;
  assign bus.if_id_instr    = valid ? instr_mem[rd_ptr] : 32'h0;
  assign bus.if_id_pc_plus4 = valid ? pc4_mem[rd_ptr] : '0;
  assign queue_count        = count;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (!redirect && count < DEPTH_C) state_next = WAIT;
      end
      WAIT: begin
        if (redirect)  state_next = ack ? IDLE : DISCARD;
        else if (ack)  state_next = (count_after < DEPTH_C) ? WAIT : IDLE;
      end
      DISCARD: begin
        if (ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state <= state_next;
      if (redirect)  fetch_pc <= redirect_aligned;
      else if (push) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      if (state == IDLE && state_next == WAIT) req_addr <= fetch_pc;
      else if (push)                           req_addr <= addr_plus;
    end
  end

  // Redirect outranks push and pop: the whole queue is dropped on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_after;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= bus.imem_rdata;
      pc4_mem[wr_ptr]   <= addr_plus;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a small latency-programmable instruction memory.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [2:0]  queue_count;
  logic        ack_force = 1'b0;
  int          lat = 0;
  int          wait_cnt;
  int          tests_run = 0;
  int          tests_failed = 0;

  fetch_prefetch_if #(.XLEN(32)) bus ();

  fetch_prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus.master),
    .queue_count (queue_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] addr);
    return {16'hC0DE, addr[15:0]};
  endfunction

  // Memory acks after lat idle cycles of a live request; ack_force injects a stray ack.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (!bus.imem_req || bus.imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  always_comb begin
    bus.imem_ack   = ack_force | (bus.imem_req && (wait_cnt >= lat));
    bus.imem_rdata = word(bus.imem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy, input int latency);
    redirect = 1'b0;
    ack_force = 1'b0;
    lat = latency;
    bus.if_id_ready = rdy;
    #2 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.if_id_ready = 1'b1;
    lat = 0;
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (bus.imem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_req got %0b want 0", bus.imem_req); end
    tests_run++; if (bus.imem_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_addr got %h want 0", bus.imem_addr); end
    tests_run++; if (bus.if_id_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid got %0b want 0", bus.if_id_valid); end
    tests_run++; if (bus.if_id_instr !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_instr got %h want 0", bus.if_id_instr); end
    tests_run++; if (bus.if_id_pc_plus4 !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_pc4 got %h want 0", bus.if_id_pc_plus4); end
    tests_run++; if (queue_count !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_count got %0d want 0", queue_count); end
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++; if (bus.imem_req !== 1'b1 || bus.if_id_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL first_issue req/valid got %0b/%0b want 1/0", bus.imem_req, bus.if_id_valid); end
    tick();
    tests_run++; if (bus.if_id_valid !== 1'b1 || bus.if_id_pc_plus4 !== 32'h4) begin tests_failed++; $display("[TB] FAIL first_valid valid/pc4 got %0b/%h want 1/4", bus.if_id_valid, bus.if_id_pc_plus4); end
  endtask

  task automatic test_zero_wait();
    do_reset(1'b1, 0);
    tick();
    tick();
    for (int k = 1; k <= 6; k++) begin
      tests_run++; if (bus.if_id_pc_plus4 !== 32'(4*k) || bus.if_id_instr !== word(32'(4*(k-1)))) begin tests_failed++; $display("[TB] FAIL stream_%0d pc4/instr got %h/%h want %h/%h", k, bus.if_id_pc_plus4, bus.if_id_instr, 32'(4*k), word(32'(4*(k-1)))); end
      tests_run++; if (bus.imem_addr !== 32'(4*k) || queue_count !== 3'd1) begin tests_failed++; $display("[TB] FAIL stream_addr_%0d addr/count got %h/%0d want %h/1", k, bus.imem_addr, queue_count, 32'(4*k)); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc4;
    do_reset(1'b0, 0);
    for (int i = 0; i < 10; i++) tick();
    tests_run++; if (queue_count !== 3'd4) begin tests_failed++; $display("[TB] FAIL bp_count got %0d want 4", queue_count); end
    tests_run++; if (bus.imem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_req got %0b want 0", bus.imem_req); end
    tests_run++; if (bus.if_id_valid !== 1'b1 || bus.if_id_pc_plus4 !== 32'h4) begin tests_failed++; $display("[TB] FAIL bp_hold valid/pc4 got %0b/%h want 1/4", bus.if_id_valid, bus.if_id_pc_plus4); end
    bus.if_id_ready = 1'b1;
    exp_pc4 = 32'h4;
    for (int i = 0; i < 10; i++) begin
      tests_run++; if (bus.if_id_valid !== 1'b1 || bus.if_id_pc_plus4 !== exp_pc4 || bus.if_id_instr !== word(exp_pc4 - 32'h4)) begin tests_failed++; $display("[TB] FAIL bp_drain_%0d valid/pc4/instr got %0b/%h/%h want 1/%h/%h", i, bus.if_id_valid, bus.if_id_pc_plus4, bus.if_id_instr, exp_pc4, word(exp_pc4 - 32'h4)); end
      exp_pc4 = exp_pc4 + 32'h4;
      tick();
    end
  endtask

  task automatic test_redirect_wait();
    bit found;
    do_reset(1'b1, 3);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.imem_req === 1'b1 && bus.imem_addr === 32'h8) found = 1'b1;
      else tick();
    end
    tests_run++; if (!found) begin tests_failed++; $display("[TB] FAIL rdw_reach_8 got timeout want req on 0x8"); end
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    tests_run++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.if_id_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rdw_hold req/addr/valid got %0b/%h/%0b want 1/8/0", bus.imem_req, bus.imem_addr, bus.if_id_valid); end
    for (int i = 0; i < 20 && bus.imem_addr === 32'h8; i++) tick();
    tests_run++; if (bus.imem_addr !== 32'h100) begin tests_failed++; $display("[TB] FAIL rdw_next_addr got %h want 100", bus.imem_addr); end
    for (int i = 0; i < 20 && bus.if_id_valid !== 1'b1; i++) tick();
    tests_run++; if (bus.if_id_valid !== 1'b1 || bus.if_id_pc_plus4 !== 32'h104 || bus.if_id_instr !== word(32'h100)) begin tests_failed++; $display("[TB] FAIL rdw_first valid/pc4/instr got %0b/%h/%h want 1/104/%h", bus.if_id_valid, bus.if_id_pc_plus4, bus.if_id_instr, word(32'h100)); end
  endtask

  task automatic test_redirect_ack_pop();
    do_reset(1'b0, 0);
    tick();
    tick();
    tick();
    tests_run++; if (queue_count !== 3'd2 || bus.imem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL rap_fill count/req got %0d/%0b want 2/1", queue_count, bus.imem_req); end
    bus.if_id_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h2000;
    tick();
    redirect = 1'b0;
    tests_run++; if (queue_count !== 3'd0 || bus.if_id_valid !== 1'b0 || bus.imem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL rap_flush count/valid/req got %0d/%0b/%0b want 0/0/0", queue_count, bus.if_id_valid, bus.imem_req); end
    tick();
    tests_run++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h2000) begin tests_failed++; $display("[TB] FAIL rap_issue req/addr got %0b/%h want 1/2000", bus.imem_req, bus.imem_addr); end
    tick();
    tests_run++; if (bus.if_id_valid !== 1'b1 || bus.if_id_pc_plus4 !== 32'h2004) begin tests_failed++; $display("[TB] FAIL rap_first valid/pc4 got %0b/%h want 1/2004", bus.if_id_valid, bus.if_id_pc_plus4); end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0, 3);
    for (int i = 0; i < 40 && !(bus.if_id_valid === 1'b1 && bus.imem_req === 1'b1); i++) tick();
    tests_run++; if (bus.if_id_valid !== 1'b1 || bus.imem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL ar_setup valid/req got %0b/%0b want 1/1", bus.if_id_valid, bus.imem_req); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (bus.imem_req !== 1'b0 || bus.if_id_valid !== 1'b0 || queue_count !== 3'd0 || bus.imem_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL ar_immediate req/valid/count/addr got %0b/%0b/%0d/%h want 0/0/0/0", bus.imem_req, bus.if_id_valid, queue_count, bus.imem_addr); end
    tick();
    rst_n = 1'b1;
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    tests_run++; if (bus.if_id_valid !== 1'b0 || queue_count !== 3'd0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL ar_stray valid/count/req/addr got %0b/%0d/%0b/%h want 0/0/1/0", bus.if_id_valid, queue_count, bus.imem_req, bus.imem_addr); end
    for (int i = 0; i < 20 && bus.if_id_valid !== 1'b1; i++) tick();
    tests_run++; if (bus.if_id_pc_plus4 !== 32'h4 || queue_count !== 3'd1) begin tests_failed++; $display("[TB] FAIL ar_resume pc4/count got %h/%0d want 4/1", bus.if_id_pc_plus4, queue_count); end
  endtask

  task automatic test_wrap();
    do_reset(1'b1, 0);
    tick();
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    tests_run++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'hFFFF_FFFC || bus.if_id_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrap_align req/addr/valid got %0b/%h/%0b want 0/fffffffc/0", bus.imem_req, bus.imem_addr, bus.if_id_valid); end
    tick();
    tests_run++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("[TB] FAIL wrap_issue req/addr got %0b/%h want 1/fffffffc", bus.imem_req, bus.imem_addr); end
    tick();
    tests_run++; if (bus.if_id_valid !== 1'b1 || bus.if_id_pc_plus4 !== 32'h0 || bus.if_id_instr !== word(32'hFFFF_FFFC) || bus.imem_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL wrap_first valid/pc4/instr/addr got %0b/%h/%h/%h want 1/0/%h/0", bus.if_id_valid, bus.if_id_pc_plus4, bus.if_id_instr, bus.imem_addr, word(32'hFFFF_FFFC)); end
    tick();
    tests_run++; if (bus.if_id_pc_plus4 !== 32'h4 || bus.if_id_instr !== word(32'h0)) begin tests_failed++; $display("[TB] FAIL wrap_second pc4/instr got %h/%h want 4/%h", bus.if_id_pc_plus4, bus.if_id_instr, word(32'h0)); end
  endtask

  initial begin
    bus.if_id_ready = 1'b1;
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack_pop();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
